switch_key_reader: RTL and testbench
====================================

Name: switch_key_reader

Overview:
- Input-side counterpart to the board display/LED drivers.
- Samples the DE2 slide switches (SW[17:0]) and pushbuttons (KEY[3:0]), synchronizes and debounces them, and generates one-cycle press pulses.
- On a KEY[0] press, captures the switch word and offers it to the processor datapath through a valid/ack handshake.
- Sits between board pins and the CPU input port; it is the only place raw board inputs enter the design.

Parameters:
- DATA_W, 18, width of the switch word and of Data.
- NUM_KEYS, 4, number of pushbuttons.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key changes debounced state (bench uses 4).

Ports:
- Clock  in  1  system clock, all logic on the rising edge.
- Reset  in  1  synchronous reset, active-low.
- SW  in  DATA_W  raw slide switches, asynchronous to Clock.
- KEY  in  NUM_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous.
- KeyPulse  out  NUM_KEYS  one-cycle pulse per debounced press.
- KeyLevel  out  NUM_KEYS  debounced level, 1 = pressed.
- Data  out  DATA_W  captured switch word.
- Valid  out  1  Data is held for the consumer.
- Ack  in  1  consumer takes Data; meaningful only while Valid = 1.
- Overrun  out  1  sticky flag: a capture was dropped.

Behaviour:
Reset
- Reset = 0 at a rising edge clears everything: KeyPulse = 0, KeyLevel = 0, Data = 0, Valid = 0, Overrun = 0, all debounce counters = 0.
- Synchronizer flops and debounced states reset to "released" (1 on the raw-polarity side).
- Reset asserted mid-debounce or while Valid = 1 discards all state; no pulse is generated on exit from reset.

Synchronization
- Two-flop synchronizer on every SW and KEY bit.
- The captured word is always the synchronized SW, never the raw pins.

Debounce (per key)
- The counter increments while the synchronized input differs from the debounced state.
- The counter clears whenever they match.
- When the counter reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the debounced state flips and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES cycles never flip the state.
- KeyPulse[i] = 1 for exactly the one cycle after the debounced state goes released -> pressed. Releases produce no pulse.
- Latency: raw KEY low and held, first sampled at edge 0, gives KeyPulse high after edge DEBOUNCE_CYCLES+2 and low after the next edge.

Capture FSM (states IDLE, HOLD)
- IDLE: Valid = 0. On KeyPulse[0], Data <= synchronized SW, go to HOLD. The capture occurs on the same edge that drops KeyPulse[0].
- HOLD: Valid = 1, Data stable.
  - Ack = 1 and no KeyPulse[0]: go to IDLE; Valid = 0 next cycle.
  - KeyPulse[0] and Ack in the same cycle: load the new word, stay in HOLD. Valid stays 1 with no bubble.
  - KeyPulse[0] without Ack: the new word is dropped, Data is unchanged, and Overrun <= 1.
- Ack while in IDLE is ignored.

Overrun
- Cleared only by Reset or a KeyPulse[3] press.
- If the clear and a new overrun occur in the same cycle, the set wins.

Other keys
- KEY[1] and KEY[2] produce only KeyPulse/KeyLevel outputs; they are used for CPU single-step and run/halt elsewhere.

Width and wrap
- Debounce counter width = clog2(DEBOUNCE_CYCLES). It never wraps because it clears on reaching the limit.

Decomposition:
- Package ocs_io_pkg holds:
  - KEY_CAPTURE = 0, KEY_CLEAR = 3
  - capture state enum {IDLE, HOLD}
  - default DEBOUNCE_CYCLES
- One sub-module, key_debouncer: one bit wide, containing synchronizer, counter, debounced level and press-pulse output. It is instantiated NUM_KEYS times.
- The SW synchronizer and capture FSM live in the top module.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset: hold Reset = 0 for 3 cycles with KEY = 4'b0000 -> all outputs 0, no KeyPulse within 10 cycles after release of reset while KEY is held high.
- Clean press: SW = 18'h2A5C3, KEY[0] low at edge 0 and held -> KeyPulse[0] high for exactly one cycle after edge 6; Valid = 1 and Data = 18'h2A5C3 after edge 7; Ack pulsed one cycle -> Valid = 0 on the next cycle.
- Bounce: KEY[1] toggles low/high every 2 cycles for 20 cycles, then is held low -> no KeyPulse[1] during bouncing; exactly one pulse 7 edges after the final low.
- Overrun: capture 18'h00001 and do not Ack; press KEY[0] again with SW = 18'h3FFFF -> Data stays 18'h00001, Overrun = 1; press KEY[3] -> Overrun = 0.
- Back-to-back: with Valid = 1, drive Ack in the same cycle as the second KeyPulse[0] (SW = 18'h1234) -> Valid never drops, Data = 18'h01234, Overrun stays 0.
- Reset mid-operation: assert Reset while in HOLD and while KEY[2] is mid-debounce -> Valid = 0 and Data = 0 after that edge; no KeyPulse[2] is emitted unless the key is held for a full DEBOUNCE_CYCLES after reset is released.

Source files
------------

// File: rtl/ocs_io_pkg.sv
// Shared constants and types for the board input path (switches, pushbuttons, capture).
package ocs_io_pkg;

  localparam int unsigned KEY_CAPTURE         = 0;
  localparam int unsigned KEY_CLEAR           = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic {
    StIdle,
    StHold
  } cap_state_e;

endpackage

// File: rtl/switch_key_reader_if.sv
// Board-pin inputs plus the captured-word handshake towards the CPU input port.
interface switch_key_reader_if #(
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned NUM_KEYS = 4
);

  logic [DATA_W-1:0]   sw;
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_level;
  logic [DATA_W-1:0]   data;
  logic                valid;
  logic                ack;
  logic                overrun;

  modport master (
    input  sw, key, ack,
    output key_pulse, key_level, data, valid, overrun
  );

  modport slave (
    output sw, key, ack,
    input  key_pulse, key_level, data, valid, overrun
  );

endinterface

// File: rtl/key_debouncer.sv
// One pushbutton: two-flop synchronizer, stability counter, debounced level and press pulse.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Raw polarity throughout: 1 = released, 0 = pressed.
  logic            r_sync1, r_sync2;
  logic            r_state, r_state_q1;
  logic            r_pulse;
  logic [CntW-1:0] r_cnt;
  logic            w_mismatch, w_flip;

  assign w_mismatch = (r_sync2 != r_state);
  assign w_flip     = w_mismatch && (r_cnt == CntMax);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= 1'b1;
      r_state_q1 <= 1'b1;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_state_q1 <= r_state;
      // Pulse lands the cycle after the debounced level turns pressed.
      r_pulse    <= r_state_q1 & ~r_state;
      if (w_flip) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = ~r_state;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/switch_key_reader.sv
// Board input entry point: debounced keys, synchronized switches and a KEY[0]-triggered capture.
module switch_key_reader
  import ocs_io_pkg::*;
#(
  parameter int unsigned DATA_W          = 18,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  switch_key_reader_if.master bus
);

  logic [NUM_KEYS-1:0] w_pulse, w_level;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_key_n(bus.key[gi]),
      .o_level(w_level[gi]),
      .o_pulse(w_pulse[gi])
    );
  end

  cap_state_e        r_state, w_state_next;
  logic [DATA_W-1:0] r_sw_s1, r_sw_s2, r_data;
  logic              r_ovr;
  logic              w_cap, w_load, w_drop, w_valid;

  assign w_cap = w_pulse[KEY_CAPTURE];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_cap) w_state_next = StHold;
      StHold:  if (bus.ack && !w_cap) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_drop  = 1'b0;
    unique case (r_state)
      StIdle: w_load = w_cap;
      StHold: begin
        w_valid = 1'b1;
        w_load  = w_cap & bus.ack;
        w_drop  = w_cap & ~bus.ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_sw_s1 <= bus.sw;
      r_sw_s2 <= r_sw_s1;
      if (w_load) r_data <= r_sw_s2;
      // A dropped capture outranks a simultaneous clear request.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (w_pulse[KEY_CLEAR]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign bus.key_pulse = w_pulse;
  assign bus.key_level = w_level;
  assign bus.data      = r_data;
  assign bus.valid     = w_valid;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_switch_key_reader.sv
// Directed plus randomized bench for switch_key_reader, checked against a cycle-history model.
module tb_switch_key_reader;

  localparam int unsigned DW   = 18;
  localparam int unsigned NK   = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned HMAX = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_key_reader_if #(.DATA_W(DW), .NUM_KEYS(NK)) bus ();

  switch_key_reader #(
    .DATA_W(DW),
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n;

  // Per-edge history: raw samples, switch samples, and debounced pressed-levels.
  logic [NK-1:0] raw_h [HMAX];
  logic [DW-1:0] sw_h  [HMAX];
  logic [NK-1:0] deb_h [HMAX];
  int unsigned   run   [NK];
  logic [NK-1:0] m_pulse;
  logic          m_valid, m_ovr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic          p_cap, p_clr, set_ovr, pressed_in;
    logic [DW-1:0] word;
    n++;
    if (n >= HMAX) begin
      $display("FAIL cycle_budget cycle=%0d observed=over expected=under %0d", n, HMAX);
      $fatal(1, "cycle budget exhausted");
    end
    if (!rst_n) begin
      raw_h[n] = '1; raw_h[n-1] = '1;
      sw_h[n]  = '0; sw_h[n-1]  = '0;
      deb_h[n] = '0;
      for (int i = 0; i < NK; i++) run[i] = 0;
      m_pulse = '0; m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
    end else begin
      raw_h[n] = bus.key;
      sw_h[n]  = bus.sw;
      p_cap = m_pulse[0];
      p_clr = m_pulse[3];
      word  = sw_h[n-2];
      for (int i = 0; i < NK; i++) begin
        pressed_in  = ~raw_h[n-2][i];
        deb_h[n][i] = deb_h[n-1][i];
        if (pressed_in != deb_h[n-1][i]) begin
          run[i]++;
          if (run[i] == DB) begin
            deb_h[n][i] = pressed_in;
            run[i]      = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_pulse = deb_h[n-1] & ~deb_h[n-2];
      set_ovr = m_valid && p_cap && !bus.ack;
      if (!m_valid) begin
        if (p_cap) begin
          m_data  = word;
          m_valid = 1'b1;
        end
      end else if (p_cap) begin
        if (bus.ack) m_data = word;
      end else if (bus.ack) begin
        m_valid = 1'b0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (p_clr) m_ovr = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_pulse", 32'(bus.key_pulse), 32'(m_pulse));
    chk("key_level", 32'(bus.key_level), 32'(deb_h[n]));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("data", 32'(bus.data), 32'(m_data));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  initial begin
    int w;
    logic [NK-1:0] k;
    int unsigned b, hold;

    rst_n   = 1'b0;
    bus.key = 4'b0000;
    bus.sw  = '0;
    bus.ack = 1'b0;
    n = 1;
    raw_h[0] = '1; raw_h[1] = '1;
    sw_h[0]  = '0; sw_h[1]  = '0;
    deb_h[0] = '0; deb_h[1] = '0;
    for (int i = 0; i < NK; i++) run[i] = 0;
    m_pulse = '0; m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;

    // Reset with keys held pressed.
    ticks(3);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_pulse_level", {28'd0, bus.key_pulse | bus.key_level}, 32'd0);
    rst_n   = 1'b1;
    bus.key = 4'hF;
    ticks(10);

    // Clean KEY[0] press.
    bus.sw  = 18'h2A5C3;
    bus.key = 4'b1110;
    ticks(7);
    chk("press_pulse", 32'(bus.key_pulse[0]), 32'd1);
    tick();
    chk("press_valid", 32'(bus.valid), 32'd1);
    chk("press_data", 32'(bus.data), 32'h2A5C3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_valid", 32'(bus.valid), 32'd0);
    bus.key = 4'hF;
    ticks(8);

    // KEY[1] bounce, then a held press.
    for (int i = 0; i < 10; i++) begin
      bus.key[1] = (i % 2 == 1);
      ticks(2);
    end
    bus.key[1] = 1'b0;
    ticks(6);
    chk("bounce_early", 32'(bus.key_pulse[1]), 32'd0);
    tick();
    chk("bounce_pulse", 32'(bus.key_pulse[1]), 32'd1);
    bus.key = 4'hF;
    ticks(8);

    // Overrun and clear.
    bus.sw  = 18'h00001;
    bus.key = 4'b1110;
    ticks(8);
    bus.key = 4'hF;
    ticks(8);
    bus.sw  = 18'h3FFFF;
    bus.key = 4'b1110;
    ticks(8);
    chk("ovr_data", 32'(bus.data), 32'h00001);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    bus.key = 4'hF;
    ticks(8);
    bus.key = 4'b0111;
    ticks(8);
    chk("ovr_clear", 32'(bus.overrun), 32'd0);
    bus.key = 4'hF;
    ticks(8);

    // Back-to-back: Ack coincides with the next capture pulse.
    bus.sw = 18'h01234;
    ticks(2);
    bus.key = 4'b1110;
    w = 0;
    while (bus.key_pulse[0] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("b2b_pulse_seen", 32'(bus.key_pulse[0]), 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("b2b_valid", 32'(bus.valid), 32'd1);
    chk("b2b_data", 32'(bus.data), 32'h01234);
    chk("b2b_ovr", 32'(bus.overrun), 32'd0);
    bus.key = 4'hF;
    ticks(8);

    // Reset while holding a word and while KEY[2] is mid-debounce.
    bus.key = 4'b1011;
    ticks(3);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_data", 32'(bus.data), 32'd0);
    rst_n = 1'b1;
    ticks(8);
    chk("midrst_level", 32'(bus.key_level[2]), 32'd1);
    bus.key = 4'hF;
    ticks(8);

    // Randomized presses, glitches, acks and occasional resets.
    for (int it = 0; it < 300; it++) begin
      bus.sw = DW'($urandom);
      k = 4'hF;
      b = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) k[b] = 1'b0;
      bus.key = k;
      hold = $urandom_range(1, 9);
      for (int j = 0; j < int'(hold); j++) begin
        bus.ack = ($urandom_range(0, 3) == 0);
        rst_n   = ($urandom_range(0, 80) != 0);
        tick();
      end
      rst_n   = 1'b1;
      bus.ack = 1'b0;
    end
    bus.key = 4'hF;
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
